// File: rtl/alu_regfile_arbiter_if.sv
// Bundle of the request, response and datapath-control signals around the
// shared ALU/register-file arbiter. The slave modport is the arbiter side.
interface alu_regfile_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 5,
  parameter int ALU_CTRL   = 3
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*ADR_WIDTH-1:0]  req_rs1;
  logic [2*ADR_WIDTH-1:0]  req_rs2;
  logic [2*ADR_WIDTH-1:0]  req_rd;
  logic [2*ALU_CTRL-1:0]   req_ctrl;
  logic [2*DATA_WIDTH-1:0] req_imm;
  logic [1:0]              req_alusrc;
  logic [1:0]              req_wen;

  logic [ADR_WIDTH-1:0]    dp_r1;
  logic [ADR_WIDTH-1:0]    dp_r2;
  logic [ADR_WIDTH-1:0]    dp_r3;
  logic [ALU_CTRL-1:0]     dp_aluctrl;
  logic [DATA_WIDTH-1:0]   dp_immop;
  logic                    dp_alusrc;
  logic                    dp_regwrite;
  logic [DATA_WIDTH-1:0]   dp_aluout;
  logic                    dp_zero;

  logic                    resp_valid;
  logic                    resp_ready;
  logic                    resp_id;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_zero;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_ctrl, req_imm, req_alusrc, req_wen,
    output req_ready,
    output dp_r1, dp_r2, dp_r3, dp_aluctrl, dp_immop, dp_alusrc, dp_regwrite,
    input  dp_aluout, dp_zero,
    output resp_valid, resp_id, resp_data, resp_zero,
    input  resp_ready
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_ctrl, req_imm, req_alusrc, req_wen,
    input  req_ready,
    input  dp_r1, dp_r2, dp_r3, dp_aluctrl, dp_immop, dp_alusrc, dp_regwrite,
    output dp_aluout, dp_zero,
    input  resp_valid, resp_id, resp_data, resp_zero,
    output resp_ready
  );
endinterface

// File: rtl/alu_regfile_arbiter.sv
// Round-robin arbiter sharing one ALU/register-file datapath between two
// requesters; one operation in flight, result returned over a response channel.
module alu_regfile_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 5,
  parameter int ALU_CTRL   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_regfile_arbiter_if.slave bus,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_lastGrant;
  logic                  w_grant;
  logic                  w_accept;
  logic [1:0]            w_reqReady;

  logic [ADR_WIDTH-1:0]  r_r1;
  logic [ADR_WIDTH-1:0]  r_r2;
  logic [ADR_WIDTH-1:0]  r_r3;
  logic [ALU_CTRL-1:0]   r_aluCtrl;
  logic [DATA_WIDTH-1:0] r_immOp;
  logic                  r_aluSrc;
  logic                  r_regWrite;

  logic                  r_respValid;
  logic                  r_respId;
  logic [DATA_WIDTH-1:0] r_respData;
  logic                  r_respZero;

  logic [ADR_WIDTH-1:0]  w_selRs1;
  logic [ADR_WIDTH-1:0]  w_selRs2;
  logic [ADR_WIDTH-1:0]  w_selRd;
  logic [ALU_CTRL-1:0]   w_selCtrl;
  logic [DATA_WIDTH-1:0] w_selImm;
  logic                  w_selAluSrc;
  logic                  w_selWen;

  // Lone requester wins; on a tie the one not served last time wins.
  always_comb begin
    w_grant = ~r_lastGrant;
    case (bus.req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      default: w_grant = ~r_lastGrant;
    endcase
  end

  assign w_selRs1    = w_grant ? bus.req_rs1[2*ADR_WIDTH-1:ADR_WIDTH]    : bus.req_rs1[ADR_WIDTH-1:0];
  assign w_selRs2    = w_grant ? bus.req_rs2[2*ADR_WIDTH-1:ADR_WIDTH]    : bus.req_rs2[ADR_WIDTH-1:0];
  assign w_selRd     = w_grant ? bus.req_rd[2*ADR_WIDTH-1:ADR_WIDTH]     : bus.req_rd[ADR_WIDTH-1:0];
  assign w_selCtrl   = w_grant ? bus.req_ctrl[2*ALU_CTRL-1:ALU_CTRL]     : bus.req_ctrl[ALU_CTRL-1:0];
  assign w_selImm    = w_grant ? bus.req_imm[2*DATA_WIDTH-1:DATA_WIDTH]  : bus.req_imm[DATA_WIDTH-1:0];
  assign w_selAluSrc = w_grant ? bus.req_alusrc[1] : bus.req_alusrc[0];
  assign w_selWen    = w_grant ? bus.req_wen[1]    : bus.req_wen[0];

  assign w_accept = (r_state == IDLE) && bus.req_valid[w_grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_reqReady  = 2'b00;
    case (r_state)
      IDLE: begin
        w_reqReady[w_grant] = 1'b1;
        if (bus.req_valid[w_grant]) begin
          w_nextState = EXEC;
        end
      end
      EXEC: w_nextState = RESP;
      RESP: begin
        if (bus.resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operation fields are sampled only at the accept edge; write enable lives for the EXEC cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r1        <= '0;
      r_r2        <= '0;
      r_r3        <= '0;
      r_aluCtrl   <= '0;
      r_immOp     <= '0;
      r_aluSrc    <= 1'b0;
      r_regWrite  <= 1'b0;
      r_lastGrant <= 1'b1;
      r_respValid <= 1'b0;
      r_respId    <= 1'b0;
      r_respData  <= '0;
      r_respZero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_r1        <= w_selRs1;
            r_r2        <= w_selRs2;
            r_r3        <= w_selRd;
            r_aluCtrl   <= w_selCtrl;
            r_immOp     <= w_selImm;
            r_aluSrc    <= w_selAluSrc;
            r_regWrite  <= w_selWen;
            r_lastGrant <= w_grant;
          end
        end
        EXEC: begin
          r_respData  <= bus.dp_aluout;
          r_respZero  <= bus.dp_zero;
          r_respId    <= r_lastGrant;
          r_respValid <= 1'b1;
          r_regWrite  <= 1'b0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_respValid <= 1'b0;
          end
        end
        default: begin
          r_regWrite  <= 1'b0;
          r_respValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = w_reqReady;
  assign bus.dp_r1       = r_r1;
  assign bus.dp_r2       = r_r2;
  assign bus.dp_r3       = r_r3;
  assign bus.dp_aluctrl  = r_aluCtrl;
  assign bus.dp_immop    = r_immOp;
  assign bus.dp_alusrc   = r_aluSrc;
  assign bus.dp_regwrite = r_regWrite;
  assign bus.resp_valid  = r_respValid;
  assign bus.resp_id     = r_respId;
  assign bus.resp_data   = r_respData;
  assign bus.resp_zero   = r_respZero;
  assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_alu_regfile_arbiter.sv
// Directed bench for alu_regfile_arbiter with a behavioural register file
// and ALU standing in for the shared datapath.
module tb_alu_regfile_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 3;

  localparam logic [CW-1:0] ALU_ADD = 3'd0;
  localparam logic [CW-1:0] ALU_SUB = 3'd1;
  localparam logic [CW-1:0] ALU_AND = 3'd2;
  localparam logic [CW-1:0] ALU_OR  = 3'd3;

  logic clk;
  logic rst_n;
  logic busy;

  logic          loadEn;
  logic [AW-1:0] loadAdr;
  logic [DW-1:0] loadData;
  logic [DW-1:0] rf [0:31];
  logic [DW-1:0] opA;
  logic [DW-1:0] opB;
  logic [DW-1:0] aluOut;

  int total;
  int bad;

  alu_regfile_arbiter_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .ALU_CTRL(CW)) bus ();

  alu_regfile_arbiter #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .ALU_CTRL(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural datapath: x0 is never written, ALU result is combinational.
  always @(posedge clk) begin
    if (loadEn) begin
      rf[loadAdr] <= loadData;
    end else if (bus.dp_regwrite && bus.dp_r3 != '0) begin
      rf[bus.dp_r3] <= aluOut;
    end
  end

  always_comb begin
    opA = rf[bus.dp_r1];
    opB = bus.dp_alusrc ? bus.dp_immop : rf[bus.dp_r2];
    case (bus.dp_aluctrl)
      ALU_ADD: aluOut = opA + opB;
      ALU_SUB: aluOut = opA - opB;
      ALU_AND: aluOut = opA & opB;
      ALU_OR:  aluOut = opA | opB;
      default: aluOut = opA ^ opB;
    endcase
  end

  assign bus.dp_aluout = aluOut;
  assign bus.dp_zero   = (aluOut == '0);

  task automatic applyStimulus(input int id, input logic valid, input logic [AW-1:0] rs1,
                               input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                               input logic [CW-1:0] ctrl, input logic [DW-1:0] imm,
                               input logic alusrc, input logic wen);
    if (id == 0) begin
      bus.req_valid[0]     = valid;
      bus.req_rs1[4:0]     = rs1;
      bus.req_rs2[4:0]     = rs2;
      bus.req_rd[4:0]      = rd;
      bus.req_ctrl[2:0]    = ctrl;
      bus.req_imm[31:0]    = imm;
      bus.req_alusrc[0]    = alusrc;
      bus.req_wen[0]       = wen;
    end else begin
      bus.req_valid[1]     = valid;
      bus.req_rs1[9:5]     = rs1;
      bus.req_rs2[9:5]     = rs2;
      bus.req_rd[9:5]      = rd;
      bus.req_ctrl[5:3]    = ctrl;
      bus.req_imm[63:32]   = imm;
      bus.req_alusrc[1]    = alusrc;
      bus.req_wen[1]       = wen;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int expId;
    int id1Seen;
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    loadEn         = 1'b0;
    loadAdr        = '0;
    loadData       = '0;
    bus.req_valid  = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_rd     = '0;
    bus.req_ctrl   = '0;
    bus.req_imm    = '0;
    bus.req_alusrc = '0;
    bus.req_wen    = '0;
    bus.resp_ready = 1'b0;

    $display("[TB] preload register file and hold reset");
    @(negedge clk); loadEn = 1'b1; loadAdr = 5'd1; loadData = 32'd5;
    @(negedge clk); loadAdr = 5'd2; loadData = 32'd7;
    @(negedge clk); loadAdr = 5'd4; loadData = 32'h55;
    @(negedge clk); loadAdr = 5'd5; loadData = 32'h0;
    @(negedge clk); loadEn = 1'b0;

    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_regwrite", 32'(bus.dp_regwrite), 32'd0);
    checkOutput("rst_dp_r1", 32'(bus.dp_r1), 32'd0);
    checkOutput("rst_immop", bus.dp_immop, 32'd0);
    checkOutput("rst_resp_data", bus.resp_data, 32'd0);
    checkOutput("rst_resp_id", 32'(bus.resp_id), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single request from requester 0: x3 = x1 + x2");
    applyStimulus(0, 1'b1, 5'd1, 5'd2, 5'd3, ALU_ADD, 32'd0, 1'b0, 1'b1);
    bus.resp_ready = 1'b1;
    #1;
    checkOutput("t1_ready_idle", 32'(bus.req_ready), 32'd1);
    checkOutput("t1_busy_idle", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t1_regwrite_exec", 32'(bus.dp_regwrite), 32'd1);
    checkOutput("t1_dp_r1", 32'(bus.dp_r1), 32'd1);
    checkOutput("t1_dp_r2", 32'(bus.dp_r2), 32'd2);
    checkOutput("t1_dp_r3", 32'(bus.dp_r3), 32'd3);
    checkOutput("t1_busy_exec", 32'(busy), 32'd1);
    checkOutput("t1_ready_exec", 32'(bus.req_ready), 32'd0);
    checkOutput("t1_resp_valid_exec", 32'(bus.resp_valid), 32'd0);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("t1_resp_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("t1_resp_id", 32'(bus.resp_id), 32'd0);
    checkOutput("t1_resp_data", bus.resp_data, 32'd12);
    checkOutput("t1_resp_zero", 32'(bus.resp_zero), 32'd0);
    checkOutput("t1_regwrite_resp", 32'(bus.dp_regwrite), 32'd0);
    checkOutput("t1_x3", rf[3], 32'd12);
    @(negedge clk);
    checkOutput("t1_resp_valid_done", 32'(bus.resp_valid), 32'd0);
    checkOutput("t1_busy_done", 32'(busy), 32'd0);

    $display("[TB] immediate op from requester 1: x3 + 0xFFFFFFF4, no write");
    applyStimulus(1, 1'b1, 5'd3, 5'd0, 5'd5, ALU_ADD, 32'hFFFF_FFF4, 1'b1, 1'b0);
    #1;
    checkOutput("t3_ready_idle", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    checkOutput("t3_regwrite_exec", 32'(bus.dp_regwrite), 32'd0);
    checkOutput("t3_alusrc", 32'(bus.dp_alusrc), 32'd1);
    checkOutput("t3_immop", bus.dp_immop, 32'hFFFF_FFF4);
    checkOutput("t3_aluctrl", 32'(bus.dp_aluctrl), 32'(ALU_ADD));
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("t3_resp_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("t3_resp_id", 32'(bus.resp_id), 32'd1);
    checkOutput("t3_resp_data", bus.resp_data, 32'd0);
    checkOutput("t3_resp_zero", 32'(bus.resp_zero), 32'd1);
    checkOutput("t3_regwrite_resp", 32'(bus.dp_regwrite), 32'd0);
    @(negedge clk);
    checkOutput("t3_x5", rf[5], 32'd0);
    checkOutput("t3_x3", rf[3], 32'd12);

    $display("[TB] both requesters valid: round-robin 0,1,0,1");
    applyStimulus(0, 1'b1, 5'd1, 5'd2, 5'd6, ALU_ADD, 32'd0, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 5'd1, 5'd2, 5'd7, ALU_SUB, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      expId = k % 2;
      #1;
      checkOutput($sformatf("t2_ready_%0d", k), 32'(bus.req_ready), 32'(1 << expId));
      @(negedge clk);
      @(negedge clk);
      checkOutput($sformatf("t2_resp_id_%0d", k), 32'(bus.resp_id), 32'(expId));
      checkOutput($sformatf("t2_resp_data_%0d", k), bus.resp_data,
                  (expId == 1) ? 32'hFFFF_FFFE : 32'd12);
      @(negedge clk);
    end

    $display("[TB] backpressure: resp_ready low for 5 cycles");
    bus.req_valid[1] = 1'b0;
    bus.resp_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("t4_valid_%0d", c), 32'(bus.resp_valid), 32'd1);
      checkOutput($sformatf("t4_data_%0d", c), bus.resp_data, 32'd12);
      checkOutput($sformatf("t4_id_%0d", c), 32'(bus.resp_id), 32'd0);
      checkOutput($sformatf("t4_ready_%0d", c), 32'(bus.req_ready), 32'd0);
      checkOutput($sformatf("t4_busy_%0d", c), 32'(busy), 32'd1);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_resp_valid_after", 32'(bus.resp_valid), 32'd0);
    checkOutput("t4_ready_after", 32'(bus.req_ready), 32'd1);
    checkOutput("t4_busy_after", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t4_reaccept_busy", 32'(busy), 32'd1);
    checkOutput("t4_reaccept_r3", 32'(bus.dp_r3), 32'd6);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] reset asserted during EXEC of a write to x4");
    applyStimulus(0, 1'b1, 5'd1, 5'd2, 5'd4, ALU_ADD, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5_regwrite_exec", 32'(bus.dp_regwrite), 32'd1);
    bus.req_valid[1] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_regwrite_rst", 32'(bus.dp_regwrite), 32'd0);
    checkOutput("t5_busy_rst", 32'(busy), 32'd0);
    checkOutput("t5_resp_valid_rst", 32'(bus.resp_valid), 32'd0);
    checkOutput("t5_r3_rst", 32'(bus.dp_r3), 32'd0);
    @(negedge clk);
    checkOutput("t5_x4", rf[4], 32'h55);
    rst_n = 1'b1;
    #1;
    checkOutput("t5_ready_after", 32'(bus.req_ready), 32'd1);
    checkOutput("t5_busy_after", 32'(busy), 32'd0);
    checkOutput("t5_resp_valid_after", 32'(bus.resp_valid), 32'd0);
    bus.req_valid = 2'b00;
    @(negedge clk);

    $display("[TB] requester 1 withdraws before being granted");
    applyStimulus(0, 1'b1, 5'd1, 5'd2, 5'd6, ALU_ADD, 32'd0, 1'b0, 1'b0);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    applyStimulus(1, 1'b1, 5'd2, 5'd1, 5'd7, ALU_OR, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_resp_id", 32'(bus.resp_id), 32'd0);
    bus.req_valid[1] = 1'b0;
    id1Seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_id) id1Seen++;
    end
    checkOutput("t6_no_id1_resp", 32'(id1Seen), 32'd0);
    checkOutput("t6_busy_end", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_regfile_arbiter.md
Name: alu_regfile_arbiter

Overview:
- Shares one ALU/register-file datapath between two requesters, for example a fetch/decode sequencer and a debug/loader port.
- Accepts register-ALU operations over valid/ready, chooses one requester by round-robin, and drives the datapath control for one execute cycle.
- Captures the ALU result and zero flag, and returns them over a shared response channel with backpressure.
- Exactly one operation is in flight at a time.

Parameters:
- DATA_WIDTH, 32, datapath and immediate width
- ADR_WIDTH, 5, register address width
- ALU_CTRL, 3, ALU control field width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester operation valid; bit i is requester i
- req_ready  out  2  per-requester accept
- req_rs1  in  2*ADR_WIDTH  source register 1; requester i uses slice [i*ADR_WIDTH +: ADR_WIDTH]
- req_rs2  in  2*ADR_WIDTH  source register 2, sliced as req_rs1
- req_rd  in  2*ADR_WIDTH  destination register, sliced as req_rs1
- req_ctrl  in  2*ALU_CTRL  ALU operation, sliced likewise
- req_imm  in  2*DATA_WIDTH  immediate operand, sliced likewise
- req_alusrc  in  2  1 = ALU operand 2 is the immediate
- req_wen  in  2  1 = write the result to rd
- dp_r1, dp_r2, dp_r3  out  ADR_WIDTH each  datapath register addresses
- dp_aluctrl  out  ALU_CTRL  datapath ALU control
- dp_immop  out  DATA_WIDTH  datapath immediate
- dp_alusrc  out  1  datapath operand select
- dp_regwrite  out  1  datapath write enable
- dp_aluout  in  DATA_WIDTH  datapath ALU result (combinational)
- dp_zero  in  1  datapath zero flag
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  1  requester that issued the response
- resp_data  out  DATA_WIDTH  captured ALU result
- resp_zero  out  1  captured zero flag
- busy  out  1  high whenever state is not IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset value is IDLE.
- Reset values: all dp_* outputs 0; resp_valid, resp_id, resp_data, resp_zero 0; last_grant 1, so requester 0 wins the first contest.
- Arbitration, IDLE only:
  - grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not equal to last_grant.
  - req_ready[i] = (state==IDLE) && grant==i. It is combinational and never high for both requesters.
- Accept (IDLE, req_valid[g] high):
  - At the rising edge, latch requester g's fields into the dp_* registers.
  - dp_regwrite <= req_wen[g]; last_grant <= g; state goes to EXEC.
  - Request fields are sampled only at this edge.
- EXEC, exactly one cycle:
  - dp_* outputs hold the latched operation, so the register file writes at the end-of-EXEC edge when dp_regwrite is 1.
  - At that edge: resp_data <= dp_aluout; resp_zero <= dp_zero; resp_id <= g; resp_valid <= 1; dp_regwrite <= 0; state goes to RESP.
  - dp_regwrite is high for exactly one cycle per accepted operation with wen=1.
- RESP:
  - resp_* outputs are held stable until resp_valid && resp_ready, then resp_valid <= 0 and state goes to IDLE.
  - No new request is accepted in the handshake cycle; the next accept is earliest one cycle later.
- Latency:
  - accept edge N; EXEC during cycle N+1; resp_valid high from edge N+2.
  - Minimum issue interval is 3 cycles with resp_ready held high.
- dp_r1, dp_r2, dp_r3, dp_aluctrl, dp_immop, dp_alusrc retain their last values outside EXEC. Only dp_regwrite is qualified.
- A requester dropping valid before it is granted is legal; nothing is recorded.
- Asynchronous reset mid-operation:
  - All state clears immediately and dp_regwrite is forced to 0; the in-flight write is suppressed.
  - A pending response is discarded and last_grant returns to 1.
- Register address 0 gets no special handling here; the register file owns write suppression.

Test Plan:
- Reset, then req0 only: rs1=1, rs2=2, rd=3, ctrl=add, alusrc=0, wen=1, x1=5, x2=7 -> req_ready[0] high in IDLE; dp_regwrite high for exactly one cycle; resp_valid at N+2 with resp_id=0, resp_data=12, resp_zero=0; x3 reads 12.
- Both requesters valid continuously, resp_ready=1 -> grant order 0,1,0,1; resp_id alternates; accepts exactly 3 cycles apart.
- Immediate operation: req1 rs1=3 (=12), imm=0xFFFFFFF4, alusrc=1, ctrl=add, wen=0 -> resp_data=0, resp_zero=1; dp_regwrite stays 0 throughout; no register changes.
- Backpressure: resp_ready held low 5 cycles in RESP while req0 is valid -> resp_* stable, req_ready=0, busy=1; resp_ready high -> handshake; req0 accepted the following cycle.
- Reset asserted mid-EXEC with wen=1, rd=4 -> dp_regwrite low immediately; x4 unchanged; after release, state IDLE, resp_valid=0, requester 0 wins the next contest.
- Request withdrawn: req1_valid pulses low before grant while req0 is busy -> no response with resp_id=1 produced.
